// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the PWM ramp sequencer.
package pwm_ctrl_pkg;

  localparam int unsigned DEF_DUTY_W = 3;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam logic [DEF_DUTY_W-1:0] DUTY_MAX = {DEF_DUTY_W{1'b1}};

  typedef enum logic [2:0] {
    ST_OFF,
    ST_EVAL,
    ST_STEP,
    ST_DWELL,
    ST_RUN
  } state_e;

endpackage

// File: rtl/step_timer.sv
// Down-counter for step-hold and dwell phases; expire_c marks the final cycle of a loaded interval.
module step_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/stop and retarget sequencer driving the PWM en/inc/dec controls.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned       DUTY_W    = DEF_DUTY_W,
  parameter int unsigned       CNT_W     = DEF_CNT_W,
  parameter logic [DUTY_W-1:0] INIT_DUTY = DUTY_W'(4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DUTY_W-1:0] target,
  input  logic [CNT_W-1:0]  step_hold,
  input  logic [CNT_W-1:0]  dwell,
  output logic              pwm_en,
  output logic              duty_inc,
  output logic              duty_dec,
  output logic [DUTY_W-1:0] duty_est,
  output logic              busy,
  output logic              at_target,
  output logic              done
);

  localparam logic [DUTY_W-1:0] DUTY_TOP =
    (DUTY_W == DEF_DUTY_W) ? DUTY_W'(DUTY_MAX) : {DUTY_W{1'b1}};

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic              stop_pend_q, stop_pend_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic              pwm_en_q, pwm_en_d;
  logic              duty_inc_q, duty_inc_d;
  logic              duty_dec_q, duty_dec_d;
  logic              busy_q, busy_d;
  logic              at_target_q, at_target_d;
  logic              done_q, done_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_expire_c;
  logic [CNT_W-1:0]  hold_eff;
  logic [DUTY_W-1:0] goal;

  step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire_c (tmr_expire_c)
  );

  // Next-state, timer control and registered-output decode.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    stop_pend_d = stop_pend_q;
    duty_d      = duty_q;
    dwell_d     = dwell_q;
    tmr_load    = 1'b0;
    hold_eff    = (step_hold == '0) ? CNT_W'(1) : step_hold;
    tmr_val     = hold_eff;
    goal        = stop_pend_q ? '0 : target;

    case (state_q)
      ST_OFF: begin
        if (start && !stop) begin
          state_d     = ST_EVAL;
          stop_pend_d = 1'b0;
        end
      end
      ST_EVAL: begin
        if (stop) stop_pend_d = 1'b1;
        if (duty_q != goal) begin
          state_d  = ST_STEP;
          dir_d    = (duty_q < goal);
          tmr_load = 1'b1;
          dwell_d  = dwell;
        end else if (stop_pend_q) begin
          state_d     = ST_OFF;
          stop_pend_d = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        if (stop) stop_pend_d = 1'b1;
        if (tmr_expire_c) begin
          if (dir_q) begin
            duty_d = (duty_q == DUTY_TOP) ? duty_q : duty_q + DUTY_W'(1);
          end else begin
            duty_d = (duty_q == '0) ? duty_q : duty_q - DUTY_W'(1);
          end
          if (dwell_q != '0) begin
            state_d  = ST_DWELL;
            tmr_load = 1'b1;
            tmr_val  = dwell_q;
          end else begin
            state_d = ST_EVAL;
          end
        end
      end
      ST_DWELL: begin
        if (stop) stop_pend_d = 1'b1;
        if (tmr_expire_c) state_d = ST_EVAL;
      end
      ST_RUN: begin
        // A stop that landed during the last EVAL is still pending here.
        if (stop || stop_pend_q) begin
          stop_pend_d = 1'b1;
          state_d     = ST_EVAL;
        end else if (target != duty_q) begin
          state_d = ST_EVAL;
        end
      end
      default: state_d = ST_OFF;
    endcase

    pwm_en_d    = (state_d != ST_OFF);
    duty_inc_d  = (state_d == ST_STEP) && dir_d;
    duty_dec_d  = (state_d == ST_STEP) && !dir_d;
    busy_d      = (state_d == ST_EVAL) || (state_d == ST_STEP) || (state_d == ST_DWELL);
    at_target_d = (state_d == ST_RUN);
    // The final EVAL of a soft stop is the one entered pending with duty already at 0.
    done_d      = (state_d == ST_EVAL) && stop_pend_d && (duty_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_OFF;
      dir_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      duty_q      <= INIT_DUTY;
      dwell_q     <= '0;
      pwm_en_q    <= 1'b0;
      duty_inc_q  <= 1'b0;
      duty_dec_q  <= 1'b0;
      busy_q      <= 1'b0;
      at_target_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      stop_pend_q <= stop_pend_d;
      duty_q      <= duty_d;
      dwell_q     <= dwell_d;
      pwm_en_q    <= pwm_en_d;
      duty_inc_q  <= duty_inc_d;
      duty_dec_q  <= duty_dec_d;
      busy_q      <= busy_d;
      at_target_q <= at_target_d;
      done_q      <= done_d;
    end
  end

  assign pwm_en    = pwm_en_q;
  assign duty_inc  = duty_inc_q;
  assign duty_dec  = duty_dec_q;
  assign duty_est  = duty_q;
  assign busy      = busy_q;
  assign at_target = at_target_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench: expected per-cycle output traces are built from ramp phases, then replayed against the DUT.
module tb_pwm_ramp_ctrl;

  localparam int K_EVAL  = 0;
  localparam int K_STEP  = 1;
  localparam int K_DWELL = 2;
  localparam int K_RUN   = 3;
  localparam int K_OFF   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop;
  logic [2:0]  target;
  logic [15:0] step_hold, dwell;
  logic        pwm_en, duty_inc, duty_dec, busy, at_target, done;
  logic [2:0]  duty_est;

  pwm_ramp_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .target    (target),
    .step_hold (step_hold),
    .dwell     (dwell),
    .pwm_en    (pwm_en),
    .duty_inc  (duty_inc),
    .duty_dec  (duty_dec),
    .duty_est  (duty_est),
    .busy      (busy),
    .at_target (at_target),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   kind;
    logic en, inc, dec, busy, at, done;
    int   duty;
    int   tgt, hold, dwl;
    logic stop;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   d_m, cur_tgt, cur_hold, cur_dwell;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int kind, input logic inc, input logic dec, input logic dn);
    ent_t e;
    e.kind = kind;
    e.en   = (kind != K_OFF);
    e.inc  = inc;
    e.dec  = dec;
    e.busy = (kind == K_EVAL) || (kind == K_STEP) || (kind == K_DWELL);
    e.at   = (kind == K_RUN);
    e.done = dn;
    e.duty = d_m;
    e.tgt  = cur_tgt;
    e.hold = cur_hold;
    e.dwl  = cur_dwell;
    e.stop = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_n(input int kind, input int n);
    repeat (n) push(kind, 1'b0, 1'b0, 1'b0);
  endtask

  // One EVAL per step, max(hold,1) level cycles, then dwell idle cycles; ends on the EVAL that matches goal.
  task automatic gen_ramp(input int goal, input bit fin);
    int h;
    bit up;
    h = (cur_hold == 0) ? 1 : cur_hold;
    for (int n = 0; n < 20; n++) begin
      push(K_EVAL, 1'b0, 1'b0, fin && (d_m == goal));
      if (d_m == goal) break;
      up = (d_m < goal);
      repeat (h) push(K_STEP, up, !up, 1'b0);
      d_m = up ? d_m + 1 : d_m - 1;
      repeat (cur_dwell) push(K_DWELL, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic retarget(input int t, input int h, input int dw);
    ent_t e;
    cur_tgt = t; cur_hold = h; cur_dwell = dw;
    e = q[q.size()-1];
    e.tgt = t; e.hold = h; e.dwl = dw;
    q[q.size()-1] = e;
  endtask

  task automatic stop_last(input int h, input int dw);
    ent_t e;
    cur_hold = h; cur_dwell = dw;
    e = q[q.size()-1];
    e.stop = 1'b1; e.hold = h; e.dwl = dw;
    q[q.size()-1] = e;
    gen_ramp(0, 1'b1);
  endtask

  // Stop during entry i: the phase in progress finishes, then the ramp down starts at the next EVAL.
  task automatic stop_at(input int i);
    ent_t e;
    int j;
    e = q[i];
    e.stop = 1'b1;
    q[i] = e;
    j = q.size();
    for (int k = i + 1; k < q.size(); k++) begin
      if (q[k].kind == K_EVAL) begin
        j = k;
        break;
      end
    end
    d_m = q[j].duty;
    while (q.size() > j) void'(q.pop_back());
    gen_ramp(0, 1'b1);
  endtask

  task automatic kick();
    @(negedge clk);
    step_hold = 16'(cur_hold);
    dwell     = 16'(cur_dwell);
    target    = 3'(cur_tgt);
    stop      = 1'b0;
    start     = 1'b1;
  endtask

  task automatic run_queue(input int n);
    ent_t e;
    for (int i = 0; i < n && i < q.size(); i++) begin
      @(negedge clk);
      cyc++;
      e = q[i];
      check_eq("pwm_en",    32'(pwm_en),    32'(e.en));
      check_eq("duty_inc",  32'(duty_inc),  32'(e.inc));
      check_eq("duty_dec",  32'(duty_dec),  32'(e.dec));
      check_eq("duty_est",  32'(duty_est),  32'(e.duty));
      check_eq("busy",      32'(busy),      32'(e.busy));
      check_eq("at_target", 32'(at_target), 32'(e.at));
      check_eq("done",      32'(done),      32'(e.done));
      start     = 1'b0;
      stop      = e.stop;
      target    = 3'(e.tgt);
      step_hold = 16'(e.hold);
      dwell     = 16'(e.dwl);
    end
    q.delete();
  endtask

  task automatic check_idle_reset(input string tag);
    check_eq({tag, "_en"},   32'(pwm_en),    32'd0);
    check_eq({tag, "_inc"},  32'(duty_inc),  32'd0);
    check_eq({tag, "_dec"},  32'(duty_dec),  32'd0);
    check_eq({tag, "_duty"}, 32'(duty_est),  32'd4);
    check_eq({tag, "_busy"}, 32'(busy),      32'd0);
    check_eq({tag, "_at"},   32'(at_target), 32'd0);
    check_eq({tag, "_done"}, 32'(done),      32'd0);
  endtask

  initial begin
    int base, nidx, t2;
    int idx[$];
    rst = 1'b0; start = 1'b0; stop = 1'b0; target = '0; step_hold = '0; dwell = '0;
    repeat (2) @(negedge clk);
    check_idle_reset("reset");
    rst = 1'b1;
    d_m = 4;

    // Target equals reset duty, then retarget up to 6, then soft stop with one-cycle steps.
    cur_tgt = 4; cur_hold = 2; cur_dwell = 0;
    kick();
    gen_ramp(4, 1'b0);
    push_n(K_RUN, 2);
    retarget(6, 4, 2);
    gen_ramp(6, 1'b0);
    push_n(K_RUN, 3);
    stop_last(1, 0);
    push_n(K_OFF, 2);
    run_queue(q.size());

    // start and stop together in OFF leave the block off.
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    push_n(K_OFF, 2);
    run_queue(q.size());

    // Stop during the second cycle of an up-step.
    cur_tgt = 4; cur_hold = 1; cur_dwell = 0;
    kick();
    gen_ramp(4, 1'b0);
    push_n(K_RUN, 1);
    retarget(7, 3, 1);
    base = q.size();
    gen_ramp(7, 1'b0);
    stop_at(base + 2);
    push_n(K_OFF, 2);
    run_queue(q.size());

    // step_hold = 0 behaves as 1; retarget downward from 6 to 2.
    cur_tgt = 6; cur_hold = 0; cur_dwell = 0;
    kick();
    gen_ramp(6, 1'b0);
    push_n(K_RUN, 2);
    retarget(2, 0, 0);
    gen_ramp(2, 1'b0);
    push_n(K_RUN, 2);
    stop_last(0, 0);
    push_n(K_OFF, 2);
    run_queue(q.size());

    // Asynchronous reset in the middle of a step.
    cur_tgt = 7; cur_hold = 5; cur_dwell = 0;
    kick();
    gen_ramp(7, 1'b0);
    run_queue(3);
    #2 rst = 1'b0;
    #1 check_idle_reset("async_rst");
    @(negedge clk);
    rst = 1'b1;
    d_m = 4;
    push_n(K_OFF, 3);
    run_queue(q.size());

    // Randomized ramps, retargets and stops.
    for (int it = 0; it < 25; it++) begin
      cur_tgt = $urandom_range(0, 7); cur_hold = $urandom_range(0, 4); cur_dwell = $urandom_range(0, 2);
      kick();
      gen_ramp(cur_tgt, 1'b0);
      idx.delete();
      for (int k = 0; k < q.size(); k++)
        if (q[k].kind == K_STEP || q[k].kind == K_DWELL) idx.push_back(k);
      nidx = idx.size();
      if (($urandom_range(0, 1) == 0) && (nidx > 0)) begin
        cur_hold = $urandom_range(0, 3); cur_dwell = $urandom_range(0, 2);
        stop_at(idx[$urandom_range(0, nidx - 1)]);
      end else begin
        push_n(K_RUN, 2);
        t2 = (d_m + $urandom_range(1, 7)) % 8;
        retarget(t2, $urandom_range(0, 4), $urandom_range(0, 2));
        gen_ramp(t2, 1'b0);
        push_n(K_RUN, 2);
        stop_last($urandom_range(0, 3), $urandom_range(0, 2));
      end
      push_n(K_OFF, 2);
      run_queue(q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
